// File: rtl/lsu_pkg.sv
// Shared opcodes, funct3 encodings and FSM states for the load/store controller.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // funct3 values 011, 110 and 111 have no load/store meaning
  function automatic logic f3_defined(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the addressed byte/half down to bit 0
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Lane select followed by extension
  always_comb begin
    b_sel = 8'(rdata >> {addr_lo, 3'b000});
    h_sel = 16'(rdata >> {addr_lo[1], 4'b0000});
    data  = '0;
    case (funct3)
      F3_B:    data = {{24{b_sel[7]}}, b_sel};
      F3_H:    data = {{16{h_sel[15]}}, h_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, b_sel};
      F3_HU:   data = {16'd0, h_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// RV32I load/store sequencer for a single-ported word-wide data memory.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with err=1 instead of forcing them onto aligned lanes.
module load_store_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  lsu_state_t        state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  logic              is_mem_op;
  logic              accept;
  logic              misalign;
  logic              trap;
  logic              cnt_last;
  logic [3:0]        strb_c;
  logic [31:0]       wdata_c;
  logic [31:0]       load_data;

  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign accept    = req_valid && (state == IDLE) && is_mem_op;
  assign cnt_last  = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign trap = !f3_defined(funct3) || misalign;

  // Store lane strobes and replicated data, derived from the incoming request
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  lsu_load_align u_align (
    .rdata   (mem_rdata),
    .funct3  (f3_q),
    .addr_lo (alo_q),
    .data    (load_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = trap ? RESP : REQ;
      REQ:  if (mem_ack || cnt_last) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q     <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cnt         <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        store_q     <= (opcode == OP_STORE);
        f3_q        <= funct3;
        alo_q       <= addr[1:0];
        addr_q      <= {addr[ADDR_W-1:2], 2'b00};
        wdata_q     <= wdata_c;
        strb_q      <= strb_c;
        cnt         <= '0;
        resp_data_q <= '0;
        resp_err_q  <= trap;
      end
      if (state == REQ) begin
        if (mem_ack) begin
          resp_data_q <= store_q ? '0 : load_data;
          resp_err_q  <= 1'b0;
        end else if (cnt_last) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = resp_valid ? resp_data_q : '0;
  assign resp_err   = resp_valid && resp_err_q;
  assign mem_req    = (state == REQ);
  assign mem_we     = mem_req && store_q;
  assign mem_wstrb  = mem_we ? strb_q : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl: directed scenarios plus randomized
// requests checked against a behavioural model of the access rules.
module tb_load_store_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference load result: pick the addressed byte/half arithmetically, then extend
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned b,
                                             input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * b)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * (b / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'b010:  v = rd;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // One full request; ack_at = REQ cycle index carrying mem_ack, -1 = never ack
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    bit          is_ld, is_st, skip, timed_out;
    int unsigned b;
    logic [31:0] e_strb, e_wdata, e_data;
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    b     = a % 4;
    skip  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
    if (f3 % 4 == 1 && b % 2 != 0) skip = 1;
    if (f3 == 3'b010 && b != 0)    skip = 1;
`endif
    case (f3 % 4)
      0:       begin e_strb = 32'd1 << b;             e_wdata = (wd & 32'hFF) * 32'h01010101;   end
      1:       begin e_strb = 32'd3 << (2 * (b / 2)); e_wdata = (wd & 32'hFFFF) * 32'h00010001; end
      default: begin e_strb = 32'd15;                 e_wdata = wd;                             end
    endcase
    if (!is_st) e_strb = 32'd0;
    e_data = is_ld ? model_load(f3, b, rd) : 32'd0;

    @(negedge clk);
    check("req_ready", req_ready, 1);
    req_valid = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; opcode = 7'($urandom); addr = $urandom; wdata = $urandom;
    @(negedge clk);
    if (!is_ld && !is_st) begin
      check("drop_resp", resp_valid, 0);
      check("drop_mreq", mem_req, 0);
      check("drop_ready", req_ready, 1);
      return;
    end
    if (skip) begin
      check("trap_mreq", mem_req, 0);
      check("trap_valid", resp_valid, 1);
      check("trap_err", resp_err, 1);
      check("trap_data", resp_data, 0);
    end else begin
      timed_out = 1;
      for (int c = 0; c < TIMEOUT; c++) begin
        check("mem_req", mem_req, 1);
        check("resp_quiet", resp_valid, 0);
        if (c == 0) begin
          check("mem_addr", mem_addr, a & 32'hFFFFFFFC);
          check("mem_we", mem_we, is_st);
          check("mem_wstrb", mem_wstrb, e_strb);
          if (is_st) check("mem_wdata", mem_wdata, e_wdata);
        end
        if (c == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (c == ack_at) begin timed_out = 0; break; end
        if (c < TIMEOUT - 1) @(negedge clk);
      end
      @(negedge clk);
      check("resp_valid", resp_valid, 1);
      check("resp_err", resp_err, timed_out);
      check("resp_data", resp_data, timed_out ? 32'd0 : e_data);
      check("mreq_drop", mem_req, 0);
    end
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);
    check("ready_again", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    int          ack_at;
    int unsigned r;
    reset = 1'b1; req_valid = 1'b0; opcode = '0; funct3 = '0; addr = '0;
    wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_err", resp_err, 0);
    check("rst_data", resp_data, 0);
    check("rst_mreq", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_wstrb", mem_wstrb, 0);
    @(negedge clk); reset = 1'b0;

    run_txn(7'b0000011, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    run_txn(7'b0000011, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    run_txn(7'b0000011, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    run_txn(7'b0000011, 3'b001, 32'h102, 32'h0, 32'h80112233, 2);
    run_txn(7'b0100011, 3'b000, 32'h2, 32'h000000AB, 32'h0, 0);
    run_txn(7'b0000011, 3'b010, 32'h40, 32'h0, 32'h12345678, -1);
    run_txn(7'b0000011, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);
    run_txn(7'b0100011, 3'b010, 32'h5, 32'h11223344, 32'h0, 1);
    run_txn(7'b0000011, 3'b101, 32'h201, 32'h0, 32'hA5A5F00F, 0);
    run_txn(7'b0000011, 3'b011, 32'h0, 32'h0, 32'h0, 0);
    run_txn(7'b0110011, 3'b010, 32'h0, 32'h0, 32'h0, 0);

    // mem_ack while idle must not produce anything
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); mem_ack = 1'b0;
    check("stray_ack_resp", resp_valid, 0);
    check("stray_ack_mreq", mem_req, 0);
    check("stray_ack_ready", req_ready, 1);

    // reset while waiting in REQ
    @(negedge clk);
    req_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); check("pre_rst_mreq", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_mreq", mem_req, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_valid", resp_valid, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", resp_valid, 0);
      check("post_rst_mreq", mem_req, 0);
    end

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 5) ? 7'b0000011 : (r < 9) ? 7'b0100011 : 7'b0110011;
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'b0100011 && (f3 == 3'b100 || f3 == 3'b101)) f3 = f3 - 3'd4;
      r = $urandom_range(0, 9);
      ack_at = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 5));
      run_txn(op, f3, $urandom, $urandom, $urandom, ack_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
